jtframe_prog_bridge: RTL and testbench

JTFRAME_PROG_BRIDGE -- requirements
Module: jtframe_prog_bridge

---
 rtl/jtframe_prog_pkg.sv | 21 ++
 rtl/jtframe_prog_fifo.sv | 58 +++++
 rtl/jtframe_prog_bridge.sv | 220 ++++++++++++++++++++++
 tb/tb_jtframe_prog_bridge.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_prog_pkg.sv
// Shared types and constants for the ROM-download-to-SDRAM bridge.
// The FSM states and byte-lane masks live here so the top and bench agree on encodings.
package jtframe_prog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } prog_state_e;

    // A set mask bit means that byte lane is NOT written.
    localparam logic [1:0] MASK_LO   = 2'b10;
    localparam logic [1:0] MASK_HI   = 2'b01;
    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_ALL  = 2'b11;

    function automatic logic [1:0] lane_mask(input logic odd);
        return odd ? MASK_HI : MASK_LO;
    endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// Synchronous FIFO with full/empty flags; storage is not reset, only the pointers are.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module jtframe_prog_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             wr_en, rd_en;

    // Extra pointer bit distinguishes full from empty when the indices match.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_en    = pop & ~empty;
        wr_en    = push & (~full | rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        dout = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/jtframe_prog_bridge.sv
// Turns the I/O controller's byte stream into masked 16-bit SDRAM write requests via a FIFO.
// Define JTFRAME_PROG_PAIR_EN to merge even/odd byte pairs into a single full-word write.
import jtframe_prog_pkg::*;

module jtframe_prog_bridge #(
    parameter int SDRAMW = 22,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic              prog_we,
    input  logic              prog_ack,
    input  logic              prog_rdy,
    output logic              dwnld_busy,
    output logic              overflow
);

    // Entry layout: {word address, 16-bit data, 2-bit mask}.
    localparam int EW = SDRAMW + 18;

    logic              dl_q;
    logic              dl_rise;
    logic              in_range;
    logic              byte_vld;
    logic              byte_drop;
    logic              byte_odd;
    logic [SDRAMW-1:0] byte_addr;
    logic [EW-1:0]     byte_entry;

    logic              push;
    logic [EW-1:0]     push_entry;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EW-1:0]     fifo_head;
    logic              hold_busy;

    prog_state_e       state_q, state_d;
    logic              prog_we_q, prog_we_d;
    logic [SDRAMW-1:0] prog_addr_q, prog_addr_d;
    logic [15:0]       prog_data_q, prog_data_d;
    logic [1:0]        prog_mask_q, prog_mask_d;
    logic              overflow_q, overflow_d;
    logic              busy_q, busy_d;

    always_comb begin
        dl_rise    = downloading & ~dl_q;
        in_range   = ((ioctl_addr >> (SDRAMW + 1)) == '0);
        byte_vld   = downloading & ioctl_wr & in_range;
        byte_drop  = downloading & ioctl_wr & ~in_range;
        byte_odd   = ioctl_addr[0];
        byte_addr  = ioctl_addr[SDRAMW:1];
        byte_entry = {byte_addr, ioctl_dout, ioctl_dout, lane_mask(byte_odd)};
    end

`ifdef JTFRAME_PROG_PAIR_EN
    logic          dl_fall;
    logic          hold_vld_q, hold_vld_d;
    logic [EW-1:0] hold_q, hold_d;
    logic          hold_odd;

    // A held odd byte can never be merged, so it leaves on the first free cycle.
    always_comb begin
        dl_fall    = dl_q & ~downloading;
        hold_odd   = (hold_q[1:0] == MASK_HI);
        push       = 1'b0;
        push_entry = byte_entry;
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        if (byte_vld) begin
            if (hold_vld_q && !hold_odd && byte_odd && (hold_q[EW-1:18] == byte_addr)) begin
                push       = 1'b1;
                push_entry = {byte_addr, ioctl_dout, hold_q[9:2], MASK_NONE};
                hold_vld_d = 1'b0;
            end else if (hold_vld_q) begin
                push       = 1'b1;
                push_entry = hold_q;
                hold_d     = byte_entry;
            end else if (!byte_odd) begin
                hold_vld_d = 1'b1;
                hold_d     = byte_entry;
            end else begin
                push       = 1'b1;
            end
        end else if (hold_vld_q && (hold_odd || dl_fall)) begin
            push       = 1'b1;
            push_entry = hold_q;
            hold_vld_d = 1'b0;
        end
        hold_busy = hold_vld_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_vld_q <= 1'b0;
        end else begin
            hold_vld_q <= hold_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end
`else
    always_comb begin
        push       = byte_vld;
        push_entry = byte_entry;
        hold_busy  = 1'b0;
    end
`endif

    jtframe_prog_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_entry),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head stays in the FIFO until the SDRAM reports completion, then it is popped.
    always_comb begin
        state_d     = state_q;
        prog_we_d   = prog_we_q;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;
        prog_mask_d = prog_mask_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d     = REQ;
                    prog_we_d   = 1'b1;
                    prog_addr_d = fifo_head[EW-1:18];
                    prog_data_d = fifo_head[17:2];
                    prog_mask_d = fifo_head[1:0];
                end
            end
            REQ: begin
                if (prog_ack) begin
                    prog_we_d = 1'b0;
                    if (prog_rdy) begin
                        fifo_pop = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (prog_rdy) begin
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                prog_we_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (byte_drop || (push && fifo_full && !fifo_pop)) begin
            overflow_d = 1'b1;
        end else if (dl_rise) begin
            overflow_d = 1'b0;
        end
        busy_d = downloading | ~fifo_empty | (state_q != IDLE) | hold_busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
            prog_mask_q <= MASK_ALL;
        end else begin
            state_q     <= state_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
            prog_mask_q <= prog_mask_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q       <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            dl_q       <= downloading;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign prog_we    = prog_we_q;
    assign prog_addr  = prog_addr_q;
    assign prog_data  = prog_data_q;
    assign prog_mask  = prog_mask_q;
    assign overflow   = overflow_q;
    assign dwnld_busy = busy_q;

endmodule

// File: tb/tb_jtframe_prog_bridge.sv
// Directed bench for jtframe_prog_bridge (SDRAMW=22, DEPTH=4); odd byte addresses are used
// outside the pairing section so the expectations hold with or without JTFRAME_PROG_PAIR_EN.
module tb_jtframe_prog_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        prog_ack;
    logic        prog_rdy;
    logic        dwnld_busy;
    logic        overflow;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    jtframe_prog_bridge #(
        .SDRAMW (22),
        .DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .prog_ack    (prog_ack),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
    endtask

    // Wait (bounded) for a request, check it, then ack and complete it on separate cycles.
    task automatic complete_write(input string tag, input logic [21:0] a,
                                  input logic [15:0] d, input logic [1:0] m);
        for (int i = 0; i < 20 && prog_we !== 1'b1; i++) @(negedge clk);
        chk({tag, "_we"},   prog_we,   1);
        chk({tag, "_addr"}, prog_addr, a);
        chk({tag, "_data"}, prog_data, d);
        chk({tag, "_mask"}, prog_mask, m);
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        prog_rdy = 1'b1;
        @(negedge clk);
        prog_rdy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        downloading = 1'b0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        ioctl_wr    = 1'b0;
        prog_ack    = 1'b0;
        prog_rdy    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_we",   prog_we,    0);
        chk("rst_addr", prog_addr,  0);
        chk("rst_data", prog_data,  0);
        chk("rst_mask", prog_mask,  2'b11);
        chk("rst_busy", dwnld_busy, 0);
        chk("rst_ovf",  overflow,   0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte at odd address 5
        downloading = 1'b1;
        @(negedge clk);
        send_byte(25'h000005, 8'hA5);
        chk("single_we_early", prog_we, 0);
        @(negedge clk);
        chk("single_we",   prog_we,   1);
        chk("single_addr", prog_addr, 22'd2);
        chk("single_data", prog_data, 16'hA5A5);
        chk("single_mask", prog_mask, 2'b01);
        repeat (3) @(negedge clk);
        chk("single_hold_we",   prog_we,   1);
        chk("single_hold_addr", prog_addr, 22'd2);
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        chk("single_wait_we", prog_we, 0);
        prog_rdy = 1'b1;
        @(negedge clk);
        prog_rdy = 1'b0;
        chk("single_busy", dwnld_busy, 1);
        repeat (2) @(negedge clk);
        chk("single_idle_we",   prog_we,   0);
        chk("single_idle_addr", prog_addr, 22'd2);

        // Backpressure: six bytes, four fit
        for (int i = 0; i < 6; i++) begin
            send_byte(25'h000101 + 25'(2 * i), 8'h10 + 8'(i));
        end
        chk("bp_ovf", overflow, 1);
        complete_write("bp0", 22'h080, 16'h1010, 2'b01);
        complete_write("bp1", 22'h081, 16'h1111, 2'b01);
        complete_write("bp2", 22'h082, 16'h1212, 2'b01);
        complete_write("bp3", 22'h083, 16'h1313, 2'b01);
        repeat (5) @(negedge clk);
        chk("bp_no_fifth", prog_we, 0);

        // Same-cycle ack and rdy
        send_byte(25'h000201, 8'h77);
        send_byte(25'h000203, 8'h88);
        for (int i = 0; i < 20 && prog_we !== 1'b1; i++) @(negedge clk);
        chk("sc_first_addr", prog_addr, 22'h100);
        chk("sc_first_data", prog_data, 16'h7777);
        prog_ack = 1'b1;
        prog_rdy = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        prog_rdy = 1'b0;
        chk("sc_idle_we", prog_we, 0);
        @(negedge clk);
        chk("sc_next_we",   prog_we,   1);
        chk("sc_next_addr", prog_addr, 22'h101);
        complete_write("sc_next", 22'h101, 16'h8888, 2'b01);

        // Overflow stays through the fall and clears on the rise
        downloading = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovf_busy_low", dwnld_busy, 0);
        chk("ovf_sticky",   overflow,   1);
        downloading = 1'b1;
        @(negedge clk);
        chk("ovf_clear", overflow, 0);

        // Out-of-range address
        send_byte(25'h0800000, 8'h99);
        repeat (4) @(negedge clk);
        chk("oor_we",  prog_we,  0);
        chk("oor_ovf", overflow, 1);
        downloading = 1'b0;
        @(negedge clk);
        downloading = 1'b1;
        @(negedge clk);
        chk("oor_ovf_clear", overflow, 0);

        // Strobe outside the download window is ignored
        downloading = 1'b0;
        @(negedge clk);
        send_byte(25'h000007, 8'h42);
        repeat (4) @(negedge clk);
        chk("ign_we",   prog_we,    0);
        chk("ign_busy", dwnld_busy, 0);
        chk("ign_ovf",  overflow,   0);

        // Reset while a request is pending
        downloading = 1'b1;
        @(negedge clk);
        send_byte(25'h000009, 8'h5A);
        send_byte(25'h00000B, 8'h6B);
        for (int i = 0; i < 20 && prog_we !== 1'b1; i++) @(negedge clk);
        chk("rreq_we",   prog_we,   1);
        chk("rreq_addr", prog_addr, 22'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rreq_async_we",   prog_we,    0);
        chk("rreq_async_busy", dwnld_busy, 0);
        chk("rreq_async_mask", prog_mask,  2'b11);
        @(negedge clk);
        downloading = 1'b0;
        rst_n       = 1'b1;
        repeat (5) @(negedge clk);
        chk("rreq_after_we",   prog_we,    0);
        chk("rreq_after_busy", dwnld_busy, 0);

`ifdef JTFRAME_PROG_PAIR_EN
        // Byte pairing and flush on download end
        downloading = 1'b1;
        @(negedge clk);
        send_byte(25'h000010, 8'h11);
        send_byte(25'h000011, 8'h22);
        complete_write("pair", 22'h008, 16'h2211, 2'b00);
        send_byte(25'h000020, 8'h33);
        repeat (4) @(negedge clk);
        chk("pair_held_we",   prog_we,    0);
        chk("pair_held_busy", dwnld_busy, 1);
        downloading = 1'b0;
        complete_write("pair_flush", 22'h010, 16'h3333, 2'b10);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
